top_level: RTL and testbench



---
 rtl/top_level_pkg.sv | 34 +++
 rtl/top_level_alu.sv | 26 ++
 rtl/top_level.sv | 93 +++++++++
 tb/tb_top_level.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// rtl/top_level_pkg.sv - shared constants, opcode/funct encodings and instruction ROM image
package top_level_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;

  // Populated words at the bottom of the ROM; everything above reads as zero (NOP)
  localparam int ROM_LEN = 5;
  localparam logic [XLEN-1:0] ROM_INIT [ROM_LEN] = '{
    32'h0022_1820,  // add $3,$1,$2
    32'h00A1_2022,  // sub $4,$5,$1
    32'h00EC_3024,  // and $6,$7,$12
    32'h012A_4025,  // or  $8,$9,$10
    32'h0022_582A   // slt $11,$1,$2
  };

  function automatic logic [XLEN-1:0] rom_word(input int unsigned idx);
    case (idx)
      0:       return ROM_INIT[0];
      1:       return ROM_INIT[1];
      2:       return ROM_INIT[2];
      3:       return ROM_INIT[3];
      4:       return ROM_INIT[4];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/top_level_alu.sv
// rtl/top_level_alu.sv - R-type ALU: add/sub/and/or/slt with a supported flag
module alu_rtype
  import top_level_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      funct,
  output logic [XLEN-1:0] result,
  output logic            supported
);

  // Decode funct into a result; unknown functs produce zero and no writeback
  always_comb begin
    result    = '0;
    supported = 1'b1;
    case (funct)
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_SLT:   result = ($signed(a) < $signed(b)) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/top_level.sv
// rtl/top_level.sv - two-stage MIPS-style slice: PC + ROM fetch, IF/ID, R-type execute/writeback
module top_level
  import top_level_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en1,
  input  logic            fetch_en2,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] instruccion_fetch,
  output logic [XLEN-1:0] instruccion_decode,
  output logic [XLEN-1:0] data_out_final
);

  localparam int IDX_W = $clog2(IMEM_WORDS);

  logic [IDX_W-1:0] rom_idx;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [5:0]       funct;
  logic [XLEN-1:0]  regs [32];
  logic [XLEN-1:0]  rs_val;
  logic [XLEN-1:0]  rt_val;
  logic [XLEN-1:0]  alu_result;
  logic             alu_supported;
  logic             exec_ok;
  logic [XLEN-1:0]  exec_result;
  logic             unused_bits;

  // Word index wraps naturally by taking only the low index bits above the byte offset
  assign rom_idx           = pc_current[IDX_W+1:2];
  assign instruccion_fetch = rom_word(32'(rom_idx));

  assign opcode = instruccion_decode[31:26];
  assign rs     = instruccion_decode[25:21];
  assign rt     = instruccion_decode[20:16];
  assign rd     = instruccion_decode[15:11];
  assign funct  = instruccion_decode[5:0];

  // Byte offset, PC bits above the ROM span and shamt play no part in this slice
  assign unused_bits = ^{pc_current[XLEN-1:IDX_W+2], pc_current[1:0], instruccion_decode[10:6]};

  assign rs_val = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? '0 : regs[rt];

  alu_rtype u_alu (
    .a         (rs_val),
    .b         (rt_val),
    .funct     (funct),
    .result    (alu_result),
    .supported (alu_supported)
  );

  assign exec_ok     = alu_supported && (opcode == OP_RTYPE);
  assign exec_result = exec_ok ? alu_result : '0;

  // Program counter: advance one word per fetch_en1 edge, 32-bit wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_current <= RESET_PC;
    end else if (fetch_en1) begin
      pc_current <= pc_current + 32'd4;
    end
  end

  // IF/ID register and registered ALU result share the fetch_en2 enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruccion_decode <= '0;
      data_out_final     <= '0;
    end else if (fetch_en2) begin
      instruccion_decode <= instruccion_fetch;
      data_out_final     <= exec_result;
    end
  end

  // Register file writeback; same edge as IF/ID reload so the next instruction sees it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= XLEN'(i);
      end
    end else if (fetch_en2 && exec_ok && (rd != 5'd0)) begin
      regs[rd] <= exec_result;
    end
  end

endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - self-checking bench for top_level with a behavioural reference model
module tb_top_level;

  logic        clk;
  logic        reset;
  logic        fetch_en1;
  logic        fetch_en2;
  logic [31:0] pc_current;
  logic [31:0] instruccion_fetch;
  logic [31:0] instruccion_decode;
  logic [31:0] data_out_final;

  int total;
  int bad;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ifid;
  logic [31:0] m_dout;
  logic [31:0] m_regs [32];
  logic [31:0] prog [5];

  top_level #(.IMEM_WORDS(64), .RESET_PC(32'h0)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_en1          (fetch_en1),
    .fetch_en2          (fetch_en2),
    .pc_current         (pc_current),
    .instruccion_fetch  (instruccion_fetch),
    .instruccion_decode (instruccion_decode),
    .data_out_final     (data_out_final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_fetch(input logic [31:0] pc);
    int unsigned idx;
    idx = (pc / 4) % 64;
    return (idx < 5) ? prog[idx] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_ifid = 32'h0;
    m_dout = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = i;
  endtask

  // one clock edge of the architectural model
  task automatic model_edge(input logic e1, input logic e2);
    int unsigned op, f, s, t, d;
    logic [31:0] a, b, r;
    bit ok;
    if (e2) begin
      op = m_ifid >> 26;
      s  = (m_ifid >> 21) % 32;
      t  = (m_ifid >> 16) % 32;
      d  = (m_ifid >> 11) % 32;
      f  = m_ifid % 64;
      a  = (s == 0) ? 32'h0 : m_regs[s];
      b  = (t == 0) ? 32'h0 : m_regs[t];
      ok = (op == 0);
      r  = 32'h0;
      if (ok) begin
        if (f == 32)      r = a + b;
        else if (f == 34) r = a - b;
        else if (f == 36) r = a & b;
        else if (f == 37) r = a | b;
        else if (f == 42) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else begin
          ok = 0;
          r  = 32'h0;
        end
      end
      m_dout = r;
      if (ok && d != 0) m_regs[d] = r;
      m_ifid = m_fetch(m_pc);
    end
    if (e1) m_pc = m_pc + 4;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},  pc_current,         m_pc);
    check({tag, ".if"},  instruccion_fetch,  m_fetch(m_pc));
    check({tag, ".id"},  instruccion_decode, m_ifid);
    check({tag, ".out"}, data_out_final,     m_dout);
  endtask

  task automatic step(input logic e1, input logic e2, input string tag);
    fetch_en1 = e1;
    fetch_en2 = e2;
    @(posedge clk);
    model_edge(e1, e2);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #12;
    reset = 1'b0;
    #1;
    check_all("rst");
  endtask

  initial begin
    logic [31:0] expseq [7];
    total = 0;
    bad   = 0;
    prog  = '{32'h00221820, 32'h00A12022, 32'h00EC3024, 32'h012A4025, 32'h0022582A};
    expseq = '{32'd0, 32'd3, 32'd4, 32'd4, 32'd11, 32'd1, 32'd0};

    // reset held 30 ns, then idle
    reset = 1'b1;
    fetch_en1 = 1'b0;
    fetch_en2 = 1'b0;
    model_reset();
    #30;
    reset = 1'b0;
    #1;
    check("reset.pc", pc_current, 32'h0);
    check("reset.if", instruccion_fetch, 32'h00221820);
    check("reset.id", instruccion_decode, 32'h0);
    check("reset.out", data_out_final, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "idle");

    // PC only
    step(1'b1, 1'b0, "pc1");
    check("pc1.abs", pc_current, 32'd4);
    check("pc1.word", instruccion_fetch, 32'h00A12022);
    step(1'b1, 1'b0, "pc2");
    check("pc2.word", instruccion_fetch, 32'h00EC3024);
    step(1'b1, 1'b0, "pc3");
    check("pc3.abs", pc_current, 32'd12);
    check("pc3.word", instruccion_fetch, 32'h012A4025);
    check("pc3.id", instruccion_decode, 32'h0);

    // program run from reset with both enables
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, "run");
      if (i == 0) check("run.id0", instruccion_decode, 32'h00221820);
      check($sformatf("run.seq%0d", i), data_out_final, expseq[i]);
    end

    // re-latch same word: add repeatedly, reg3 stays 3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, "relatch");
      check("relatch.id", instruccion_decode, 32'h00221820);
      if (i > 0) check("relatch.out", data_out_final, 32'd3);
    end

    // PC wrap of ROM index
    do_reset();
    for (int i = 0; i < 63; i++) step(1'b1, 1'b0, "walk");
    check("walk.top", instruccion_fetch, 32'h0);
    step(1'b1, 1'b0, "wrap");
    check("wrap.pc", pc_current, 32'h100);
    check("wrap.if", instruccion_fetch, 32'h00221820);

    // async reset between edges, then replay
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "pre");
    #3;
    reset = 1'b1;
    #1;
    check("async.pc", pc_current, 32'h0);
    check("async.id", instruccion_decode, 32'h0);
    check("async.out", data_out_final, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, "replay");
      check($sformatf("replay.seq%0d", i), data_out_final, expseq[i]);
    end

    // randomized enables against the model, with rare resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
